// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int XLEN        = 32;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;
    localparam int RSP_DEPTH   = 2;

    // One response as it travels from the latency pipeline to the fetch unit.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } imem_rsp_t;

    // A byte address faults when it is not word aligned or its word index
    // lies beyond the end of the array.
    function automatic logic addr_fault(input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] depth_words);
        logic [XLEN-1:0] word_idx;
        word_idx   = {2'b00, addr[XLEN-1:2]};
        addr_fault = (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry in-order response buffer between the latency pipeline and the
// fetch interface. Flush empties it in one edge.
module rsp_fifo
    import imem_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  imem_rsp_t push_rsp,
    input  logic      pop,
    input  logic      flush,
    output logic      full,
    output logic      empty,
    output imem_rsp_t head_rsp
);

    imem_rsp_t  slot_reg [RSP_DEPTH];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign full     = (count_reg == 2'd2);
    assign empty    = (count_reg == 2'd0);
    assign do_pop   = pop && !empty;
    // A pop on the same edge frees a slot, so a push into a full buffer is
    // only refused when nothing leaves.
    assign do_push  = push && (!full || do_pop);
    assign head_rsp = slot_reg[rd_ptr_reg];

    // Pointer / occupancy bookkeeping and slot writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            slot_reg[0] <= '0;
            slot_reg[1] <= '0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                slot_reg[wr_ptr_reg] <= push_rsp;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with a fixed-latency, in-order, flushable fetch port
// and a side write port for program loading.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,   // power of two, at least 2
    parameter int LATENCY     = 2       // LATENCY_MIN..LATENCY_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            flush,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int              AW          = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] DEPTH_LIMIT = XLEN'(DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Pipeline: data carries the raw array word, err is decided at accept,
    // and valid marks a live (unflushed) request in that stage.
    logic [XLEN-1:0] pipe_data_reg  [LATENCY];
    logic            pipe_err_reg   [LATENCY];
    logic            pipe_valid_reg [LATENCY];

    logic [1:0] count_reg;
    logic       accept;
    logic       consume;
    logic       load_ok;
    logic       fifo_full;
    logic       fifo_empty;
    imem_rsp_t  push_rsp;
    imem_rsp_t  head_rsp;

    // fifo_full implies count_reg == 2, so it only backs up the count check.
    assign req_ready = (count_reg < 2'd2) && !fifo_full && !flush && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign consume   = rsp_valid && rsp_ready;
    assign load_ok   = load_en && !addr_fault(load_addr, DEPTH_LIMIT);

    // Program-load write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // Registered array read: the word as it stood before any
                // load landing on the same edge.
                always_ff @(posedge clk) begin
                    pipe_data_reg[0] <= mem[req_addr[AW+1:2]];
                end

                // Capture acceptance and fault status of the new request.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pipe_valid_reg[0] <= 1'b0;
                        pipe_err_reg[0]   <= 1'b0;
                    end else begin
                        pipe_valid_reg[0] <= accept;
                        pipe_err_reg[0]   <= addr_fault(req_addr, DEPTH_LIMIT);
                    end
                end
            end else begin : g_next
                // Carry the data word one stage further.
                always_ff @(posedge clk) begin
                    pipe_data_reg[gi] <= pipe_data_reg[gi-1];
                end

                // Advance validity and fault status; flush kills the slot.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_err_reg[gi]   <= 1'b0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1] && !flush;
                        pipe_err_reg[gi]   <= pipe_err_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Faulting accesses return zero data.
    always_comb begin
        push_rsp.err  = pipe_err_reg[LATENCY-1];
        push_rsp.data = pipe_err_reg[LATENCY-1] ? '0 : pipe_data_reg[LATENCY-1];
    end

    rsp_fifo u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pipe_valid_reg[LATENCY-1]),
        .push_rsp (push_rsp),
        .pop      (consume),
        .flush    (flush),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_rsp (head_rsp)
    );

    assign rsp_data = fifo_empty ? '0   : head_rsp.data;
    assign rsp_err  = fifo_empty ? 1'b0 : head_rsp.err;

    // Outstanding-request count: accepted but not yet consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 2'd0;
        end else if (flush) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_reg + 2'(accept) - 2'(consume);
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios followed by a
// randomized run against a queue-based reference model.
module tb_imem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic        flush, load_en;
    logic [31:0] req_addr, rsp_data, load_addr, load_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          arrive;
    } exp_t;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_addr  = '0; rsp_ready = 1'b0; flush = 1'b0;
        load_en   = 1'b0; load_addr = '0; load_data = '0;
    endtask

    function automatic logic model_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (int'(a[31:2]) >= DEPTH) || (a[31:2] >= 30'(DEPTH));
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b1;
        req_valid = 1'b1;
        tick(); tick(); settle();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        $display("reset: ready=%b after release", req_ready);
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i) << 2;
            load_data = $urandom;
            model_mem[i] = load_data;
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic test_basic();
        idle();
        load_en = 1'b1; load_addr = 32'h0; load_data = 32'h0000_0013;
        model_mem[0] = 32'h0000_0013;
        tick();
        load_en = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        settle();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        settle();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid k=0: got %b want 0", rsp_valid); end
        for (int k = 1; k <= LAT; k++) begin
            tick(); settle();
            total++; if (rsp_valid !== (k == LAT)) begin bad++; $display("FAIL basic_latency k=%0d: got %b want %b", k, rsp_valid, k == LAT); end
        end
        total++; if (rsp_data !== 32'h0000_0013 || rsp_err !== 1'b0) begin bad++; $display("FAIL basic_data: got %h/%b want 00000013/0", rsp_data, rsp_err); end
        $display("basic: addr=0 data=%h err=%b", rsp_data, rsp_err);
        tick(); settle();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        idle();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            settle();
            total++; if (req_ready !== (i < 2)) begin bad++; $display("FAIL bp_ready i=%0d: got %b want %b", i, req_ready, i < 2); end
            tick();
        end
        req_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            settle();
            total++; if (rsp_valid !== 1'b1 || rsp_data !== model_mem[0] || req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold h=%0d: got v=%b d=%h r=%b want v=1 d=%h r=0", h, rsp_valid, rsp_data, req_ready, model_mem[0]);
            end
            tick();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (rsp_valid !== 1'b1 || rsp_data !== model_mem[i]) begin bad++; $display("FAIL bp_order i=%0d: got v=%b d=%h want v=1 d=%h", i, rsp_valid, rsp_data, model_mem[i]); end
            $display("backpressure: rsp %0d data=%h", i, rsp_data);
            tick();
        end
        settle();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        errs  [4];
        logic [31:0] want;
        addrs = '{32'h0000_0002, 32'h0000_1000, 32'h0000_0FFC, 32'h8000_0000};
        errs  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            idle();
            rsp_ready = 1'b1; req_valid = 1'b1; req_addr = addrs[i];
            want = errs[i] ? 32'h0 : model_mem[addrs[i][11:2]];
            tick();
            req_valid = 1'b0;
            for (int k = 0; k < LAT; k++) tick();
            settle();
            total++; if (rsp_valid !== 1'b1 || rsp_err !== errs[i] || rsp_data !== want) begin
                bad++; $display("FAIL err_rsp addr=%h: got v=%b e=%b d=%h want v=1 e=%b d=%h", addrs[i], rsp_valid, rsp_err, rsp_data, errs[i], want);
            end
            $display("errors: addr=%h err=%b data=%h", addrs[i], rsp_err, rsp_data);
            tick();
        end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            settle();
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_pre_ready i=%0d: got %b want 1", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        tick(); settle();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", rsp_valid); end
        flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
        settle();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready_low: got %b want 0", req_ready); end
        tick();
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        settle();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL flush_after: got v=%b r=%b want v=0 r=1", rsp_valid, req_ready); end
        for (int h = 0; h < 4; h++) begin
            tick(); settle();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_stale h=%0d: got %b want 0", h, rsp_valid); end
        end
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick(); settle();
            total++; if (rsp_valid !== (k == LAT)) begin bad++; $display("FAIL flush_new_latency k=%0d: got %b want %b", k, rsp_valid, k == LAT); end
        end
        total++; if (rsp_data !== model_mem[2]) begin bad++; $display("FAIL flush_new_data: got %h want %h", rsp_data, model_mem[2]); end
        $display("flush: new rsp data=%h", rsp_data);
        tick(); settle();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_single: got %b want 0", rsp_valid); end
    endtask

    task automatic test_load_collision();
        idle();
        load_en = 1'b1; load_addr = 32'h4; load_data = 32'h0;
        model_mem[1] = 32'h0;
        tick();
        load_data = 32'hDEAD_BEEF; req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
        tick();
        model_mem[1] = 32'hDEAD_BEEF;
        load_en = 1'b0; req_valid = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        tick(); settle();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin bad++; $display("FAIL collide_old: got v=%b d=%h want v=1 d=00000000", rsp_valid, rsp_data); end
        $display("collision: same-edge rsp data=%h", rsp_data);
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        tick(); settle();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL collide_new: got v=%b d=%h want v=1 d=deadbeef", rsp_valid, rsp_data); end
        $display("collision: next rsp data=%h", rsp_data);
        tick();
    endtask

    task automatic test_async_reset();
        idle();
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < LAT; k++) tick();
        settle();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", rsp_valid); end
        rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'h0) begin
            bad++; $display("FAIL areset_immediate: got v=%b r=%b d=%h want 0/0/0", rsp_valid, req_ready, rsp_data);
        end
        tick(); tick();
        rst = 1'b0;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        settle();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL areset_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick(); settle();
            total++; if (rsp_valid !== (k == LAT)) begin bad++; $display("FAIL areset_latency k=%0d: got %b want %b", k, rsp_valid, k == LAT); end
        end
        total++; if (rsp_data !== model_mem[0] || rsp_err !== 1'b0) begin bad++; $display("FAIL areset_data: got %h/%b want %h/0", rsp_data, rsp_err, model_mem[0]); end
        $display("async reset: post-reset rsp data=%h", rsp_data);
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r == 8) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) return 32'(DEPTH + int'($urandom_range(0, 500))) << 2;
        return {1'b1, 31'($urandom)} & 32'hFFFF_FFFC;
    endfunction

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          cyc;
        logic        exp_valid, exp_ready;
        logic [31:0] a;
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cyc = 0;
        for (int n = 0; n < 1500; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = rand_addr();
            load_data = $urandom;
            settle();
            exp_valid = (q.size() > 0) && (q[0].arrive <= cyc);
            exp_ready = (q.size() < 2) && !flush;
            total++; if (rsp_valid !== exp_valid) begin bad++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, rsp_valid, exp_valid); end
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, req_ready, exp_ready); end
            if (exp_valid) begin
                total++; if (rsp_data !== q[0].data || rsp_err !== q[0].err) begin
                    bad++; $display("FAIL rand_rsp cyc=%0d: got %h/%b want %h/%b", cyc, rsp_data, rsp_err, q[0].data, q[0].err);
                end
                if (rsp_ready && !flush) $display("random: cyc=%0d rsp data=%h err=%b", cyc, rsp_data, rsp_err);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && rsp_ready) void'(q.pop_front());
                if (req_valid && exp_ready) begin
                    a = req_addr;
                    e.err    = model_fault(a);
                    e.data   = e.err ? 32'h0 : model_mem[a[11:2]];
                    e.arrive = cyc + 1 + LAT;
                    q.push_back(e);
                end
            end
            if (load_en && !model_fault(load_addr)) model_mem[load_addr[11:2]] = load_data;
            tick();
            cyc++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_backpressure();
        test_errors();
        test_flush();
        test_load_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set instruction words stored; power of two.
REQ-002 Parameter LATENCY, default 2, SHALL set accept-to-response cycles; legal range 1..4.
REQ-003 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of the requested instruction.
REQ-008 rsp_valid  output  1  response word present.
REQ-009 rsp_ready  input  1  fetch consumes the response this cycle.
REQ-010 rsp_data  output  32  instruction word.
REQ-011 rsp_err  output  1  access fault for this response.
REQ-012 flush  input  1  discard all outstanding responses (branch redirect).
REQ-013 load_en  input  1  program-load write strobe.
REQ-014 load_addr  input  32  byte address of the load word.
REQ-015 load_data  input  32  word written on load_en.

Function
REQ-016 A request SHALL be accepted on a clock edge where req_valid and req_ready are both high.
REQ-017 Outstanding count (accepted, not yet consumed) SHALL be 0..2; req_ready = (count < 2) and not flush and not rst.
REQ-018 rsp_valid SHALL first assert exactly LATENCY cycles after the accepting edge if no older response is pending; otherwise on the edge after the older response is consumed.
REQ-019 Responses SHALL be returned in acceptance order; none dropped or duplicated except by flush.
REQ-020 A response SHALL be consumed on an edge where rsp_valid and rsp_ready are both high; rsp_data and rsp_err SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-021 Accept and consume in the same cycle at count 2 SHALL be impossible (req_ready low); at count 1 both SHALL occur, count stays 1.
REQ-022 rsp_err SHALL be 1 and rsp_data 0 when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS; otherwise rsp_err 0 and rsp_data = memory word at req_addr[31:2].
REQ-023 Read data SHALL be the array contents sampled on the accepting edge; a load to the same word on that edge SHALL not affect it.
REQ-024 load_en SHALL write load_data to word load_addr[31:2] on the edge; misaligned or out-of-range loads SHALL be ignored; loads SHALL not stall requests.
REQ-025 flush high on an edge SHALL empty the latency pipeline and response buffer, set count 0, and drive rsp_valid 0 from the next cycle; no request is accepted that cycle.
REQ-026 Responses to requests accepted after a flush SHALL obey REQ-018 unaffected by the flushed ones.
REQ-027 A consume coinciding with flush SHALL still be treated as discarded; no error or side effect.

Reset
REQ-028 While rst is high: req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, count 0, pipeline valid bits 0.
REQ-029 Assertion mid-operation SHALL discard all outstanding responses immediately (asynchronously).
REQ-030 Memory array contents SHALL not be reset.
REQ-031 First acceptance SHALL be possible on the first edge after rst deasserts.

Structure
REQ-032 Package imem_pkg SHALL hold XLEN = 32, the LATENCY legality bounds, and a packed response typedef (data, err).
REQ-033 The 2-entry in-order response buffer SHALL be sub-module rsp_fifo (push, pop, flush, full, empty) instantiated once.
REQ-034 The latency pipeline SHALL be LATENCY stages of {valid, response} shift registers ahead of rsp_fifo.

Verification
REQ-035 Load 0x00000013 at 0x0, rsp_ready=1, request 0x0 -> rsp_valid at accept+2, rsp_data=0x00000013, rsp_err=0.
REQ-036 rsp_ready=0, requests 0x0,0x4,0x8 back-to-back -> two accepted, req_ready=0 on third; release rsp_ready -> data in order 0x0, 0x4.
REQ-037 Request 0x2 and request 0x1000 (DEPTH 1024) -> both rsp_err=1, rsp_data=0.
REQ-038 Two outstanding, flush for one cycle -> rsp_valid 0 next cycle, count 0; new request 0x8 -> single response at accept+2.
REQ-039 Load 0xDEADBEEF to 0x4 on same edge as request 0x4 (old 0x0) -> response 0x0; next request 0x4 -> 0xDEADBEEF.
REQ-040 Assert rst with one response held -> rsp_valid and req_ready 0 within the cycle; after deassert request 0x0 -> normal response.
